// File: rtl/video_pattern_tx_pkg.sv
// Shared types and constants for the test-pattern video source: pattern selection,
// timing state, colour-bar table and default 640x480 timing.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timing_state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Element [0] is the leftmost bar.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic int axisTotal(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_pattern_tx_if.sv
// Pixel-stream bus between the pattern source and a processing stage.
// Optional frame_cnt exists only when VPG_FRAME_COUNTER_EN is defined.
interface video_pattern_tx_if;
    logic [23:0] vid_data;
    logic        pHSync;
    logic        pVSync;
    logic        pVDE;
    logic        frame_start;
`ifdef VPG_FRAME_COUNTER_EN
    logic [15:0] frame_cnt;

    modport master (output vid_data, pHSync, pVSync, pVDE, frame_start, frame_cnt);
    modport slave  (input  vid_data, pHSync, pVSync, pVDE, frame_start, frame_cnt);
`else
    modport master (output vid_data, pHSync, pVSync, pVDE, frame_start);
    modport slave  (input  vid_data, pHSync, pVSync, pVDE, frame_start);
`endif
endinterface

// File: rtl/video_pattern_tx_timing_counter.sv
// Horizontal/vertical counters, IDLE/RUN frame FSM and unregistered sync/DE decode.
// Start and stop are honoured only on frame boundaries.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_pix,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] hCnt,
    output logic [VW-1:0] vCnt,
    output logic          rawDe,
    output logic          rawHSync,
    output logic          rawVSync,
    output logic          frameFirst,
    output timing_state_e state
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DE_END   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DE_END   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hCnt  <= '0;
            vCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hCnt <= '0;
                    vCnt <= '0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (hCnt == H_LAST) begin
                        hCnt <= '0;
                        if (vCnt == V_LAST) begin
                            // Last pixel of the frame: the only point where a stop is honoured.
                            vCnt <= '0;
                            if (!en) state <= IDLE;
                        end else begin
                            vCnt <= vCnt + VW'(1);
                        end
                    end else begin
                        hCnt <= hCnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic isRun;
    assign isRun      = (state == RUN);
    assign rawDe      = isRun && (hCnt < H_DE_END) && (vCnt < V_DE_END);
    assign rawHSync   = isRun && (hCnt >= H_SYNC_BEG) && (hCnt < H_SYNC_END);
    assign rawVSync   = isRun && (vCnt >= V_SYNC_BEG) && (vCnt < V_SYNC_END);
    assign frameFirst = isRun && (hCnt == '0) && (vCnt == '0);

endmodule

// File: rtl/video_pattern_tx.sv
// Self-contained test-pattern frame source: timing plus RGB patterns, all outputs registered.
// Define VPG_FRAME_COUNTER_EN to add frame_cnt and a per-frame scrolling gradient.
module video_pattern_tx
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                clk_pix,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          pattern_sel,
    input  logic [23:0]         solid_rgb,
    output timing_state_e       dbgState,
    video_pattern_tx_if.master  vid
);

    localparam int HW = $clog2(axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = $clog2(axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP));

    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;
    logic          rawDe, rawHSync, rawVSync, frameFirst;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .en         (en),
        .hCnt       (hCnt),
        .vCnt       (vCnt),
        .rawDe      (rawDe),
        .rawHSync   (rawHSync),
        .rawVSync   (rawVSync),
        .frameFirst (frameFirst),
        .state      (dbgState)
    );

    pattern_e    shadowSel, activeSel;
    logic [23:0] shadowRgb, activeRgb;
    logic [2:0]  barIdx;
    logic [7:0]  gradLevel;
    logic        checkerOn;
    logic [23:0] pixel;

`ifdef VPG_FRAME_COUNTER_EN
    logic [15:0] frameCnt;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst)             frameCnt <= '0;
        else if (frameFirst) frameCnt <= frameCnt + 16'd1;
    end

    // The first pixel already sees the count that frame_start is about to publish.
    assign gradLevel     = 8'(hCnt) + 8'(frameFirst ? frameCnt + 16'd1 : frameCnt);
    assign vid.frame_cnt = frameCnt;
`else
    assign gradLevel = 8'(hCnt);
`endif

    always_comb begin
        // Inputs are taken live on the first pixel, from the shadow copy thereafter.
        activeSel = frameFirst ? pattern_e'(pattern_sel) : shadowSel;
        activeRgb = frameFirst ? solid_rgb : shadowRgb;
        barIdx    = 3'(hCnt / HW'(H_ACTIVE / 8));
        checkerOn = |((8'(hCnt) ^ 8'(vCnt)) & 8'h10);
        pixel     = '0;
        case (activeSel)
            PAT_BARS:  pixel = BAR_TABLE[barIdx];
            PAT_GRAD:  pixel = {3{gradLevel}};
            PAT_CHECK: pixel = checkerOn ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID: pixel = activeRgb;
            default:   pixel = '0;
        endcase
    end

    logic [23:0] dataReg;
    logic        hsReg, vsReg, deReg, fsReg;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            dataReg   <= '0;
            hsReg     <= ~SYNC_POL;
            vsReg     <= ~SYNC_POL;
            deReg     <= 1'b0;
            fsReg     <= 1'b0;
            shadowSel <= PAT_BARS;
            shadowRgb <= '0;
        end else begin
            dataReg <= rawDe ? pixel : 24'h000000;
            hsReg   <= rawHSync ? SYNC_POL : ~SYNC_POL;
            vsReg   <= rawVSync ? SYNC_POL : ~SYNC_POL;
            deReg   <= rawDe;
            fsReg   <= frameFirst;
            if (frameFirst) begin
                shadowSel <= activeSel;
                shadowRgb <= solid_rgb;
            end
        end
    end

    assign vid.vid_data    = dataReg;
    assign vid.pHSync      = hsReg;
    assign vid.pVSync      = vsReg;
    assign vid.pVDE        = deReg;
    assign vid.frame_start = fsReg;

endmodule

// File: tb/tb_video_pattern_tx.sv
// Bench for video_pattern_tx on a reduced 64x40 raster so whole frames fit in a short run.
// Expected pixels and timing come from frame-position arithmetic on the pattern rules.
module tb_video_pattern_tx;
    import video_timing_pkg::*;

    localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam bit SYNC_POL = 1'b0;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    localparam logic [27:0] RESET_T = {24'h0, ~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0};

    logic          clk_pix = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    pattern_sel;
    logic [23:0]   solid_rgb;
    timing_state_e dbgState;

    video_pattern_tx_if vid ();

    video_pattern_tx #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) dut (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .dbgState    (dbgState),
        .vid         (vid)
    );

    // clock
    always #5 clk_pix = ~clk_pix;

    // scoreboard and model state
    logic [27:0] exp_q[$];
    logic [27:0] cap [FRAME];
    int          checks = 0, failures = 0;
    int          modelPos = -1, modelFrames = 0;
    logic [1:0]  frameSel = 2'd0;
    logic [23:0] frameRgb = 24'h0;
    int          tickNo = 0, fsCount = 0, fsLast = 0, fsPrev = 0, deCount = 0;
    int          winErr = 0, winPos = 0;
    logic [27:0] winObs, winExp;

    function automatic logic [27:0] obs();
        return {vid.vid_data, vid.pHSync, vid.pVSync, vid.pVDE, vid.frame_start};
    endfunction

    function automatic int pp(int v, int h);
        return v * H_TOTAL + h;
    endfunction

    // Expected output tuple for the sample produced by frame position pos (-1 = idle).
    function automatic logic [27:0] model_out(int pos, logic [1:0] sel, logic [23:0] rgb, int fno);
        int h, v;
        logic de, hs, vs, fs;
        logic [23:0] d;
        logic [7:0] g;
        if (pos < 0) return RESET_T;
        h  = pos % H_TOTAL;
        v  = pos / H_TOTAL;
        de = (h < H_ACTIVE) && (v < V_ACTIVE);
        hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        fs = (pos == 0);
        d  = 24'h0;
`ifdef VPG_FRAME_COUNTER_EN
        g  = 8'((h + fno) % 256);
`else
        g  = 8'(h % 256 + fno * 0);
`endif
        if (de) begin
            case (sel)
                2'd0:    d = BARS[h * 8 / H_ACTIVE];
                2'd1:    d = {g, g, g};
                2'd2:    d = (((h / 16) + (v / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                default: d = rgb;
            endcase
        end
        return {d, hs, vs, de, fs};
    endfunction

    // driver: one clock, model advanced on the same inputs the DUT samples
    task automatic tick();
        logic [27:0] e, o;
        int p;
        p = modelPos;
        if (p == 0) begin
            frameSel = pattern_sel;
            frameRgb = solid_rgb;
            modelFrames++;
        end
        exp_q.push_back(model_out(p, frameSel, frameRgb, modelFrames));
        if (p < 0 || p == FRAME - 1) modelPos = en ? 0 : -1;
        else                         modelPos = p + 1;
        @(posedge clk_pix);
        #1;
        tickNo++;
        o = obs();
        e = exp_q.pop_front();
        if (o !== e) begin
            winErr++;
            if (winErr == 1) begin winObs = o; winExp = e; winPos = p; end
        end
        if (p >= 0) cap[p] = o;
        if (o[1]) deCount++;
        if (o[0]) begin fsPrev = fsLast; fsLast = tickNo; fsCount++; end
    endtask

    task automatic run_to_pos(int target);
        int budget;
        budget = 2 * FRAME + 10;
        do begin
            tick();
            budget--;
        end while (modelPos != target && budget > 0);
    endtask

    task automatic check_win(string tag);
        checks++;
        assert (winErr === 0) else begin
            failures++;
            $error("FAIL %s: %0d bad cycles, first at pos %0d observed=%h expected=%h",
                   tag, winErr, winPos, winObs, winExp);
        end
        winErr = 0;
    endtask

    task automatic check_val(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int n, enTick, relTick, fsHold, deHold;
        rst = 1'b1; en = 1'b0; pattern_sel = 2'd0; solid_rgb = 24'h0;
        #12;
        check_val("reset_values", 32'(obs()), 32'(RESET_T));
        #10 rst = 1'b0;
        @(posedge clk_pix); #1;

        // idle with en low
        for (int i = 0; i < 1000; i++) tick();
        check_win("idle_1000");

        // frame A: colour bars
        en = 1'b1; pattern_sel = 2'd0;
        enTick = tickNo;
        run_to_pos(0);
        run_to_pos(0);
        check_win("frame_bars");
        check_val("fs_latency", 32'(fsLast - enTick), 32'd2);
        check_val("bar_h7",  32'(cap[pp(0, 7)][27:4]),  32'hFFFFFF);
        check_val("bar_h8",  32'(cap[pp(0, 8)][27:4]),  32'hFFFF00);
        check_val("bar_h63", 32'(cap[pp(0, 63)][27:4]), 32'h000000);
        check_val("bar_v39_h24", 32'(cap[pp(39, 24)][27:4]), 32'h00FF00);
        n = 0;
        for (int h = 0; h < H_TOTAL; h++) n += int'(cap[pp(0, h)][1]);
        check_val("de_per_line", 32'(n), 32'(H_ACTIVE));
        n = 0;
        for (int h = 0; h < H_TOTAL; h++) n += int'(!cap[pp(3, h)][3]);
        check_val("hsync_width", 32'(n), 32'(H_SYNC));
        check_val("hsync_first", 32'(cap[pp(0, 68)][3]), 32'd0);
        check_val("hsync_before", 32'(cap[pp(0, 67)][3]), 32'd1);
        check_val("vsync_line42", 32'(cap[pp(42, 5)][2]), 32'd0);
        check_val("vsync_line41", 32'(cap[pp(41, 79)][2]), 32'd1);
        check_val("vsync_line44", 32'(cap[pp(44, 0)][2]), 32'd1);
        n = 0;
        for (int i = 0; i < FRAME; i++) if (!cap[i][1] && cap[i][27:4] != 24'h0) n++;
        check_val("blank_data_zero", 32'(n), 32'd0);

        // frame B: switch to solid mid-frame, frame C: solid
        run_to_pos(pp(20, 0));
        pattern_sel = 2'd3; solid_rgb = 24'h123456;
        run_to_pos(0);
        check_win("frame_midchange");
        check_val("midchange_keeps_bars", 32'(cap[pp(30, 8)][27:4]), 32'hFFFF00);
        run_to_pos(0);
        check_win("frame_solid");
        check_val("solid_first", 32'(cap[0][27:4]), 32'h123456);
        check_val("solid_last", 32'(cap[pp(39, 63)][27:4]), 32'h123456);
        check_val("frame_period", 32'(fsLast - fsPrev), 32'(FRAME));

        // frame D: checkerboard
        pattern_sel = 2'd2;
        run_to_pos(0);
        check_win("frame_checker");
        check_val("chk_0_0",   32'(cap[pp(0, 0)][27:4]),   32'h000000);
        check_val("chk_0_16",  32'(cap[pp(0, 16)][27:4]),  32'hFFFFFF);
        check_val("chk_16_0",  32'(cap[pp(16, 0)][27:4]),  32'hFFFFFF);
        check_val("chk_16_16", 32'(cap[pp(16, 16)][27:4]), 32'h000000);

        // frame E: gradient
        pattern_sel = 2'd1;
        run_to_pos(0);
        check_win("frame_gradient");
`ifdef VPG_FRAME_COUNTER_EN
        check_val("grad_h37", 32'(cap[pp(2, 37)][27:4]), 32'({3{8'(37 + modelFrames)}}));
`else
        check_val("grad_h37", 32'(cap[pp(2, 37)][27:4]), 32'h252525);
`endif

        // randomized pattern changes at frame starts and mid-frame
        for (int k = 0; k < 3; k++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            solid_rgb   = 24'($urandom);
            run_to_pos($urandom_range(1, FRAME - 1));
            pattern_sel = 2'($urandom_range(0, 3));
            solid_rgb   = 24'($urandom);
            run_to_pos(0);
            check_win($sformatf("frame_random%0d", k));
        end

        // drop en mid-frame: frame completes, then idle
        run_to_pos(pp(20, 0));
        en = 1'b0;
        run_to_pos(-1);
        check_win("frame_stop");
        check_val("stop_last_active", 32'(cap[pp(39, 63)][1]), 32'd1);
        fsHold = fsCount; deHold = deCount;
        for (int i = 0; i < 500; i++) tick();
        check_win("idle_after_stop");
        check_val("no_fs_after_stop", 32'(fsCount), 32'(fsHold));
        check_val("no_de_after_stop", 32'(deCount), 32'(deHold));

        // asynchronous reset mid-line, then restart
        en = 1'b1;
        run_to_pos(0);
        run_to_pos(pp(5, 30));
        check_win("pre_reset");
        #2 rst = 1'b1;
        #1;
        check_val("async_reset", 32'(obs()), 32'(RESET_T));
        modelPos = -1; modelFrames = 0;
        #3 rst = 1'b0;
        relTick = tickNo;
        tick();
        tick();
        check_val("fs_after_reset", 32'(fsLast - relTick), 32'd2);
        run_to_pos(0);
        check_win("frame_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
